// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared memory port, counts retired instructions and halts on illegal opcode or memory timeout.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       imm_type,
    output logic             reg_write,
    output logic             wb_sel,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             halted,
    output logic [1:0]       fault
);

    // wait_cnt only has to reach MEM_TIMEOUT-1: the limit cycle itself is decided combinationally
    localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {C_R, C_I, C_LOAD, C_STORE, C_BRANCH} iclass_t;

    state_t           state_q, state_d;
    iclass_t          class_q, class_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [1:0]       fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign retired_cnt = cnt_q;

    // State, class, timeout counter, fault code and retire counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            class_q    <= C_R;
            wait_cnt_q <= '0;
            fault_q    <= 2'b00;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            class_q    <= class_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state and control decode; every output is held at 0 while rst is high
    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        wait_cnt_d = '0;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = 2'b00;
        imm_type   = 2'b00;
        reg_write  = 1'b0;
        wb_sel     = 1'b0;
        retire     = 1'b0;
        halted     = 1'b0;
        fault      = fault_q;
        if (rst) begin
            fault = 2'b00;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        fault_d = 2'b10;
                        state_d = S_HALT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WW'(1);
                    end
                end
                S_DECODE: begin
                    state_d = S_EXEC;
                    case (opcode)
                        OPC_R:      class_d = C_R;
                        OPC_I:      class_d = C_I;
                        OPC_LOAD:   class_d = C_LOAD;
                        OPC_STORE:  class_d = C_STORE;
                        OPC_BRANCH: class_d = C_BRANCH;
                        default: begin
                            fault_d = 2'b01;
                            state_d = S_HALT;
                        end
                    endcase
                end
                S_EXEC: begin
                    case (class_q)
                        C_R: begin
                            alu_op  = 2'b10;
                            state_d = S_WB;
                        end
                        C_I: begin
                            alu_src_b = 1'b1;
                            alu_op    = 2'b10;
                            state_d   = S_WB;
                        end
                        C_LOAD: begin
                            alu_src_b = 1'b1;
                            state_d   = S_MEM;
                        end
                        C_STORE: begin
                            alu_src_b = 1'b1;
                            imm_type  = 2'b01;
                            state_d   = S_MEM;
                        end
                        C_BRANCH: begin
                            alu_op   = 2'b01;
                            imm_type = 2'b10;
                            retire   = 1'b1;
                            state_d  = S_FETCH;
                            if (branch_taken) begin
                                pc_write = 1'b1;
                                pc_src   = 1'b1;
                            end else begin
                                pc_write = 1'b0;
                            end
                        end
                        default: begin
                            fault_d = 2'b01;
                            state_d = S_HALT;
                        end
                    endcase
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (class_q == C_STORE);
                    if (mem_ready) begin
                        if (class_q == C_STORE) begin
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        fault_d = 2'b10;
                        state_d = S_HALT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WW'(1);
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = (class_q == C_LOAD);
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = S_HALT;
                end
            endcase
            if (retire) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected control words are queued
// from an instruction table and hand-built corner sequences, then compared cycle by cycle.
module tb_multicycle_ctrl;

    localparam int MT = 4;
    localparam int CW = 3;

    // Control word bit layout matches the packing of cw_obs below
    localparam logic [14:0] C_REQ   = 15'h4000;
    localparam logic [14:0] C_WE    = 15'h2000;
    localparam logic [14:0] C_ASEL  = 15'h1000;
    localparam logic [14:0] C_IRW   = 15'h0800;
    localparam logic [14:0] C_PCW   = 15'h0400;
    localparam logic [14:0] C_PCSRC = 15'h0200;
    localparam logic [14:0] C_SRCB  = 15'h0100;
    localparam logic [14:0] C_FN    = 15'h0080;
    localparam logic [14:0] C_SUB   = 15'h0040;
    localparam logic [14:0] C_IMMB  = 15'h0020;
    localparam logic [14:0] C_IMMS  = 15'h0010;
    localparam logic [14:0] C_RW    = 15'h0008;
    localparam logic [14:0] C_WBS   = 15'h0004;
    localparam logic [14:0] C_RET   = 15'h0002;
    localparam logic [14:0] C_HALT  = 15'h0001;
    localparam logic [14:0] C_NONE  = 15'h0000;

    logic          clk = 1'b0;
    logic          rst, branch_taken, mem_ready;
    logic [6:0]    opcode;
    logic          mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src_b;
    logic [1:0]    alu_op, imm_type, fault;
    logic          reg_write, wb_sel, retire, halted;
    logic [CW-1:0] retired_cnt;
    logic [14:0]   cw_obs;

    multicycle_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_type(imm_type), .reg_write(reg_write), .wb_sel(wb_sel),
        .retire(retire), .retired_cnt(retired_cnt), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    assign cw_obs = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src_b,
                     alu_op, imm_type, reg_write, wb_sel, retire, halted};

    typedef struct {
        logic        rst;
        logic        mr;
        logic        bt;
        logic [6:0]  opc;
        logic [14:0] cw;
        logic [1:0]  flt;
    } step_t;

    typedef struct {
        logic [31:0] instr;
        logic        bt;
        int          fw;
        int          mw;
    } vec_t;

    step_t         sb_q[$];
    vec_t          tbl[9];
    logic [6:0]    cur_opc;
    logic          cur_bt;
    logic [CW-1:0] exp_cnt;
    int            n_checks, n_errors;

    task automatic push(input logic r, input logic mr, input logic [14:0] cw, input logic [1:0] f);
        step_t s;
        s.rst = r; s.mr = mr; s.bt = cur_bt; s.opc = cur_opc; s.cw = cw; s.flt = f;
        sb_q.push_back(s);
    endtask

    // FETCH with fw not-ready cycles, then the accepting cycle and DECODE (mem_ready there is ignored)
    task automatic push_head(input logic [6:0] opc, input logic bt, input int fw);
        cur_opc = opc;
        cur_bt  = bt;
        for (int i = 0; i < fw; i++) push(1'b0, 1'b0, C_REQ, 2'b00);
        push(1'b0, 1'b1, C_REQ | C_IRW | C_PCW, 2'b00);
        push(1'b0, 1'b1, C_NONE, 2'b00);
    endtask

    task automatic push_instr(input logic [31:0] instr, input logic bt, input int fw, input int mw);
        logic [6:0] opc;
        opc = instr[6:0];
        push_head(opc, bt, fw);
        case (opc)
            7'h33: begin
                push(1'b0, 1'b1, C_FN, 2'b00);
                push(1'b0, 1'b1, C_RW | C_RET, 2'b00);
            end
            7'h13: begin
                push(1'b0, 1'b1, C_SRCB | C_FN, 2'b00);
                push(1'b0, 1'b1, C_RW | C_RET, 2'b00);
            end
            7'h03: begin
                push(1'b0, 1'b1, C_SRCB, 2'b00);
                for (int i = 0; i < mw; i++) push(1'b0, 1'b0, C_REQ | C_ASEL, 2'b00);
                push(1'b0, 1'b1, C_REQ | C_ASEL, 2'b00);
                push(1'b0, 1'b1, C_RW | C_WBS | C_RET, 2'b00);
            end
            7'h23: begin
                push(1'b0, 1'b1, C_SRCB | C_IMMS, 2'b00);
                for (int i = 0; i < mw; i++) push(1'b0, 1'b0, C_REQ | C_ASEL | C_WE, 2'b00);
                push(1'b0, 1'b1, C_REQ | C_ASEL | C_WE | C_RET, 2'b00);
            end
            default: begin
                push(1'b0, 1'b1, C_SUB | C_IMMB | C_RET | (bt ? (C_PCW | C_PCSRC) : C_NONE), 2'b00);
            end
        endcase
    endtask

    task automatic push_reset(input int n);
        for (int i = 0; i < n; i++) push(1'b1, 1'b1, C_NONE, 2'b00);
    endtask

    // Apply queued stimulus one cycle at a time and compare outputs at the falling edge
    task automatic drain(input string name);
        step_t st;
        int    k;
        k = 0;
        while (sb_q.size() > 0) begin
            st = sb_q.pop_front();
            rst = st.rst; mem_ready = st.mr; branch_taken = st.bt; opcode = st.opc;
            @(negedge clk);
            n_checks++;
            if (cw_obs !== st.cw) begin
                n_errors++;
                $display("FAIL %s step%0d ctrl got=%h exp=%h", name, k, cw_obs, st.cw);
            end
            n_checks++;
            if (fault !== st.flt) begin
                n_errors++;
                $display("FAIL %s step%0d fault got=%b exp=%b", name, k, fault, st.flt);
            end
            n_checks++;
            if (retired_cnt !== exp_cnt) begin
                n_errors++;
                $display("FAIL %s step%0d retired_cnt got=%0d exp=%0d", name, k, retired_cnt, exp_cnt);
            end
            if (st.rst) exp_cnt = '0;
            else if ((st.cw & C_RET) != C_NONE) exp_cnt = exp_cnt + 3'd1;
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    initial begin
        tbl[0] = '{32'h00B50533, 1'b0, 0, 0};
        tbl[1] = '{32'h0042A303, 1'b0, 0, 3};
        tbl[2] = '{32'hFE000EE3, 1'b1, 0, 0};
        tbl[3] = '{32'hFE000EE3, 1'b0, 0, 0};
        tbl[4] = '{32'h00150513, 1'b0, 2, 0};
        tbl[5] = '{32'h0062A223, 1'b0, 0, 1};
        tbl[6] = '{32'h00B50533, 1'b0, 3, 0};
        tbl[7] = '{32'h0042A303, 1'b0, 1, 0};
        tbl[8] = '{32'h0062A223, 1'b1, 0, 3};

        n_checks = 0; n_errors = 0; exp_cnt = '0;
        cur_opc = 7'h33; cur_bt = 1'b0;
        rst = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; opcode = 7'h33;
        @(posedge clk);
        #1;
        push_reset(2);
        drain("reset");

        // Nine retires with a 3-bit counter also exercise the wrap
        for (int v = 0; v < 9; v++) begin
            push_instr(tbl[v].instr, tbl[v].bt, tbl[v].fw, tbl[v].mw);
            drain($sformatf("vec%0d", v));
        end

        // Reset during STORE memory phase: request drops at once, count held until the edge
        push_head(7'h23, 1'b0, 0);
        push(1'b0, 1'b1, C_SRCB | C_IMMS, 2'b00);
        push(1'b0, 1'b0, C_REQ | C_ASEL | C_WE, 2'b00);
        push(1'b1, 1'b0, C_NONE, 2'b00);
        push(1'b1, 1'b1, C_NONE, 2'b00);
        push_instr(32'h00B50533, 1'b0, 0, 0);
        drain("rst_in_mem");

        // Illegal opcode: halt sticky for 10 cycles, then reset restarts cleanly
        push_head(7'h7F, 1'b0, 0);
        for (int i = 0; i < 10; i++) push(1'b0, 1'b1, C_HALT, 2'b01);
        push_reset(2);
        push_instr(32'h00B50533, 1'b0, 0, 0);
        drain("illegal");

        // Fetch timeout: four not-ready cycles reach the limit
        cur_opc = 7'h33;
        for (int i = 0; i < MT; i++) push(1'b0, 1'b0, C_REQ, 2'b00);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b1, C_HALT, 2'b10);
        push_reset(1);
        push_instr(32'h00B50533, 1'b0, MT - 1, 0);
        drain("fetch_to");

        // Data timeout on a LOAD
        push_head(7'h03, 1'b0, 0);
        push(1'b0, 1'b1, C_SRCB, 2'b00);
        for (int i = 0; i < MT; i++) push(1'b0, 1'b0, C_REQ | C_ASEL, 2'b00);
        for (int i = 0; i < 2; i++) push(1'b0, 1'b0, C_HALT, 2'b10);
        push_reset(1);
        push_instr(32'h0042A303, 1'b0, 0, MT - 1);
        drain("mem_to");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
